// File: rtl/stego_seq_ctrl_if.sv
// Handshake bundle for stego_seq_ctrl: message load, uart2sample input, bit_changer_seq link
// and sample2uart output. The controller uses the slave modport; its environment uses master.
interface stego_seq_ctrl_if #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 1,
  parameter int MSG_BITS   = 64
);
  localparam int FW = FRAME_SIZE * BPS;
  localparam int LW = $clog2(MSG_BITS + 1);

  logic                  in_msg_load;
  logic [MSG_BITS-1:0]   in_msg_data;
  logic [LW-1:0]         in_msg_len;
  logic                  in_sample_ready;
  logic [FW-1:0]         in_sample;
  logic                  out_bc_enable;
  logic [FW-1:0]         out_bc_frame;
  logic [FRAME_SIZE-1:0] out_bc_message;
  logic                  in_bc_ready;
  logic [FW-1:0]         in_bc_frame;
  logic [FW-1:0]         out_frame;
  logic                  out_ready;
  logic                  out_busy;
  logic                  out_done;
  logic                  out_overrun;
  logic                  out_timeout;
  logic                  out_load_rej;

  modport slave (
    input  in_msg_load, in_msg_data, in_msg_len, in_sample_ready, in_sample,
           in_bc_ready, in_bc_frame,
    output out_bc_enable, out_bc_frame, out_bc_message, out_frame, out_ready,
           out_busy, out_done, out_overrun, out_timeout, out_load_rej
  );

  modport master (
    output in_msg_load, in_msg_data, in_msg_len, in_sample_ready, in_sample,
           in_bc_ready, in_bc_frame,
    input  out_bc_enable, out_bc_frame, out_bc_message, out_frame, out_ready,
           out_busy, out_done, out_overrun, out_timeout, out_load_rej
  );
endinterface

// File: rtl/stego_seq_ctrl.sv
// Steganography sequencer: embeds a loaded message FRAME_SIZE bits per sample via bit_changer_seq.
// Optional macro STEGO_SEQ_CNT_EN adds out_sample_cnt / out_embed_cnt counters.
module stego_seq_ctrl #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 1,
  parameter int MSG_BITS   = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic in_clk,
  input  logic in_rst,
  stego_seq_ctrl_if.slave bus
`ifdef STEGO_SEQ_CNT_EN
  ,
  output logic [15:0] out_sample_cnt,
  output logic [15:0] out_embed_cnt
`endif
);
  localparam int FW = FRAME_SIZE * BPS;
  localparam int LW = $clog2(MSG_BITS + 1);
  localparam int PW = $clog2(MSG_BITS + FRAME_SIZE + 1);

  typedef enum logic [1:0] {IDLE, ARMED, BUSY, DONE} state_e;

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
    if (len > LW'(MSG_BITS)) return LW'(MSG_BITS);
    return len;
  endfunction

  function automatic logic [MSG_BITS-1:0] msg_mask(input logic [MSG_BITS-1:0] data,
                                                   input logic [LW-1:0] len);
    logic [MSG_BITS-1:0] m;
    for (int i = 0; i < MSG_BITS; i++) m[i] = data[i] && (i < int'(len));
    return m;
  endfunction

  function automatic logic [FRAME_SIZE-1:0] msg_slice(input logic [MSG_BITS-1:0] msg,
                                                      input logic [PW-1:0] ptr);
    logic [MSG_BITS-1:0] sh;
    sh = msg >> ptr;
    return sh[FRAME_SIZE-1:0];
  endfunction

  state_e                state_q, state_d, st;
  logic [MSG_BITS-1:0]   msg_q, msg_d;
  logic [LW-1:0]         len_q, len_d;
  logic [PW-1:0]         ptr_q, ptr_d, ptr_sum;
  logic                  hold_vld_q, hold_vld_d;
  logic [FW-1:0]         hold_data_q, hold_data_d;
  logic [FW-1:0]         cur_q, cur_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  bc_en_q, bc_en_d;
  logic [FW-1:0]         bc_frame_q, bc_frame_d;
  logic [FRAME_SIZE-1:0] bc_msg_q, bc_msg_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic                  load_rej_q, load_rej_d;
  logic                  src_vld, take;
  logic [FW-1:0]         src_data;

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    ptr_sum     = ptr_q + PW'(FRAME_SIZE);
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    cur_d       = cur_q;
    tmo_cnt_d   = tmo_cnt_q;
    bc_en_d     = 1'b0;
    bc_frame_d  = bc_frame_q;
    bc_msg_d    = bc_msg_q;
    frame_d     = frame_q;
    ready_d     = 1'b0;
    done_d      = done_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    load_rej_d  = 1'b0;
    take        = 1'b0;
    st          = state_q;

    // A load lands before any sample of the same cycle, so that sample sees the new message.
    if (bus.in_msg_load) begin
      if (state_q == BUSY) begin
        load_rej_d = 1'b1;
      end else begin
        len_d   = sat_len(bus.in_msg_len);
        msg_d   = msg_mask(bus.in_msg_data, len_d);
        ptr_d   = '0;
        done_d  = 1'b0;
        st      = (len_d != '0) ? ARMED : IDLE;
        state_d = st;
      end
    end

    src_vld  = hold_vld_q || bus.in_sample_ready;
    src_data = hold_vld_q ? hold_data_q : bus.in_sample;

    case (st)
      IDLE, DONE: begin
        // Passthrough waits a cycle after a previous out_ready so pulses never touch.
        if (src_vld && !ready_q) begin
          frame_d = src_data;
          ready_d = 1'b1;
          take    = 1'b1;
        end
      end
      ARMED: begin
        if (src_vld) begin
          bc_en_d    = 1'b1;
          bc_frame_d = src_data;
          bc_msg_d   = msg_slice(msg_d, ptr_d);
          cur_d      = src_data;
          tmo_cnt_d  = '0;
          state_d    = BUSY;
          take       = 1'b1;
        end
      end
      BUSY: begin
        if (bus.in_bc_ready) begin
          frame_d = bus.in_bc_frame;
          ready_d = 1'b1;
          ptr_d   = ptr_sum;
          if (ptr_sum >= PW'(len_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
          frame_d   = cur_q;
          ready_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ARMED;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    // Draining the hold register lets a coincident new sample refill it.
    if (take && hold_vld_q) begin
      hold_vld_d  = bus.in_sample_ready;
      hold_data_d = bus.in_sample;
    end else if (!take && bus.in_sample_ready) begin
      if (hold_vld_q) begin
        overrun_d = 1'b1;
      end else begin
        hold_vld_d  = 1'b1;
        hold_data_d = bus.in_sample;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_vld_q <= 1'b0;
      tmo_cnt_q  <= '0;
      bc_en_q    <= 1'b0;
      bc_frame_q <= '0;
      bc_msg_q   <= '0;
      frame_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      load_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_vld_q <= hold_vld_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bc_en_q    <= bc_en_d;
      bc_frame_q <= bc_frame_d;
      bc_msg_q   <= bc_msg_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      load_rej_q <= load_rej_d;
    end
  end

  always_ff @(posedge in_clk) begin
    msg_q       <= msg_d;
    len_q       <= len_d;
    hold_data_q <= hold_data_d;
    cur_q       <= cur_d;
  end

`ifdef STEGO_SEQ_CNT_EN
  logic [15:0] sample_cnt_q, sample_cnt_d, embed_cnt_q, embed_cnt_d;

  always_comb begin
    sample_cnt_d = ((bus.in_msg_load && state_q != BUSY) ? 16'd0 : sample_cnt_q)
                   + {15'd0, ready_d};
    embed_cnt_d  = embed_cnt_q + {15'd0, (state_q == BUSY) && bus.in_bc_ready};
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sample_cnt_q <= '0;
      embed_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      embed_cnt_q  <= embed_cnt_d;
    end
  end

  assign out_sample_cnt = sample_cnt_q;
  assign out_embed_cnt  = embed_cnt_q;
`endif

  assign bus.out_bc_enable  = bc_en_q;
  assign bus.out_bc_frame   = bc_frame_q;
  assign bus.out_bc_message = bc_msg_q;
  assign bus.out_frame      = frame_q;
  assign bus.out_ready      = ready_q;
  assign bus.out_busy       = (state_q == ARMED) || (state_q == BUSY);
  assign bus.out_done       = done_q;
  assign bus.out_overrun    = overrun_q;
  assign bus.out_timeout    = timeout_q;
  assign bus.out_load_rej   = load_rej_q;
endmodule

// File: tb/tb_stego_seq_ctrl.sv
// Directed bench for stego_seq_ctrl with an LSB-replacing bit_changer model (ready 3 cycles
// after enable, suppressible for the timeout case).
module tb_stego_seq_ctrl;
  localparam int BPS = 16, FRAME_SIZE = 1, MSG_BITS = 8, TIMEOUT = 16;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  always #5 in_clk = ~in_clk;

  stego_seq_ctrl_if #(.BPS(BPS), .FRAME_SIZE(FRAME_SIZE), .MSG_BITS(MSG_BITS)) bus ();

`ifdef STEGO_SEQ_CNT_EN
  logic [15:0] out_sample_cnt, out_embed_cnt;
`endif

  stego_seq_ctrl #(.BPS(BPS), .FRAME_SIZE(FRAME_SIZE), .MSG_BITS(MSG_BITS), .TIMEOUT(TIMEOUT)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus.slave)
`ifdef STEGO_SEQ_CNT_EN
    ,
    .out_sample_cnt (out_sample_cnt),
    .out_embed_cnt  (out_embed_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // bit_changer_seq model
  logic       bc_off = 1'b0;
  int         bc_cnt = 0;
  logic [15:0] bc_lat = '0;
  always @(posedge in_clk) begin
    if (in_rst) begin
      bc_cnt          <= 0;
      bus.in_bc_ready <= 1'b0;
      bus.in_bc_frame <= '0;
    end else begin
      bus.in_bc_ready <= 1'b0;
      if (bus.out_bc_enable) begin
        bc_cnt <= 3;
        bc_lat <= {bus.out_bc_frame[15:1], bus.out_bc_message};
      end else if (bc_cnt != 0) begin
        bc_cnt <= bc_cnt - 1;
        if (bc_cnt == 1 && !bc_off) begin
          bus.in_bc_ready <= 1'b1;
          bus.in_bc_frame <= bc_lat;
        end
      end
    end
  end

  int   rdy_cnt = 0, en_cnt = 0, adj_cnt = 0;
  logic prev_rdy = 1'b0;
  always @(negedge in_clk) begin
    if (bus.out_ready) begin
      rdy_cnt++;
      if (prev_rdy) adj_cnt++;
    end
    if (bus.out_bc_enable) en_cnt++;
    prev_rdy = bus.out_ready;
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    bus.in_sample       = v;
    bus.in_sample_ready = 1'b1;
    tick();
    bus.in_sample_ready = 1'b0;
  endtask

  task automatic load(input logic [7:0] d, input logic [3:0] l);
    bus.in_msg_data = d;
    bus.in_msg_len  = l;
    bus.in_msg_load = 1'b1;
    tick();
    bus.in_msg_load = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget, output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus.out_ready && c < budget);
    chk(tag, {31'd0, bus.out_ready}, 32'd1);
  endtask

  int c, base;

  initial begin
    bus.in_msg_load = 1'b0; bus.in_msg_data = '0; bus.in_msg_len = '0;
    bus.in_sample_ready = 1'b0; bus.in_sample = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, bus.out_ready}, 0);
    chk("rst_busy",  {31'd0, bus.out_busy}, 0);
    chk("rst_frame", {16'd0, bus.out_frame}, 0);
    chk("rst_flags", {28'd0, bus.out_done, bus.out_overrun, bus.out_timeout, bus.out_load_rej}, 0);
    in_rst = 1'b0;
    tick();

    // Passthrough
    send(16'h3FFF);
    chk("pt0_ready", {31'd0, bus.out_ready}, 1);
    chk("pt0_frame", {16'd0, bus.out_frame}, 32'h3FFF);
    tick(); tick(); tick();
    send(16'h01F0);
    chk("pt1_ready", {31'd0, bus.out_ready}, 1);
    chk("pt1_frame", {16'd0, bus.out_frame}, 32'h01F0);
    tick(); tick();
    chk("pt_no_enable", en_cnt, 0);

    // Embed 0b101, len 3
    load(8'h05, 4'd3);
    chk("emb_armed", {31'd0, bus.out_busy}, 1);
    send(16'h3FFF); wait_ready("emb0_rdy", 20, c);
    chk("emb0_frame", {16'd0, bus.out_frame}, 32'h3FFF);
    tick();
    send(16'h3FFF); wait_ready("emb1_rdy", 20, c);
    chk("emb1_frame", {16'd0, bus.out_frame}, 32'h3FFE);
    chk("emb1_not_done", {31'd0, bus.out_done}, 0);
    tick();
    send(16'h3FFF); wait_ready("emb2_rdy", 20, c);
    chk("emb2_frame", {16'd0, bus.out_frame}, 32'h3FFF);
    chk("emb_done", {31'd0, bus.out_done}, 1);
    tick();
    send(16'h1234);
    chk("emb_pt_ready", {31'd0, bus.out_ready}, 1);
    chk("emb_pt_frame", {16'd0, bus.out_frame}, 32'h1234);
    chk("emb_enables", en_cnt, 3);
`ifdef STEGO_SEQ_CNT_EN
    chk("cnt_sample", {16'd0, out_sample_cnt}, 4);
    chk("cnt_embed",  {16'd0, out_embed_cnt}, 3);
`endif
    tick();

    // Buffering: msg 0xA5 -> bit0=1, bit1=0; third sample overruns
    load(8'hA5, 4'd8);
    chk("buf_done_clr", {31'd0, bus.out_done}, 0);
    base = rdy_cnt;
    send(16'h1000); send(16'h2000); send(16'h3000);
    chk("buf_overrun", {31'd0, bus.out_overrun}, 1);
    wait_ready("buf0_rdy", 30, c);
    chk("buf0_frame", {16'd0, bus.out_frame}, 32'h1001);
    wait_ready("buf1_rdy", 30, c);
    chk("buf1_frame", {16'd0, bus.out_frame}, 32'h2000);
    repeat (20) tick();
    chk("buf_count", rdy_cnt - base, 2);

    // Timeout: msg 0b10, len 2
    load(8'h02, 4'd2);
    bc_off = 1'b1;
    chk("tmo_pre", {31'd0, bus.out_timeout}, 0);
    send(16'hAAAA); wait_ready("tmo_rdy", 40, c);
    chk("tmo_cycles", c, TIMEOUT);
    chk("tmo_flag", {31'd0, bus.out_timeout}, 1);
    chk("tmo_frame", {16'd0, bus.out_frame}, 32'hAAAA);
    bc_off = 1'b0;
    tick();
    send(16'h5555); wait_ready("tmo_next_rdy", 20, c);
    chk("tmo_ptr_kept", {16'd0, bus.out_frame}, 32'h5554);
    tick();

    // Load while BUSY is rejected; message (bit1=1, len 2) still completes
    send(16'h0F00);
    load(8'hFF, 4'd8);
    chk("rej_pulse", {31'd0, bus.out_load_rej}, 1);
    wait_ready("rej_rdy", 20, c);
    chk("rej_frame", {16'd0, bus.out_frame}, 32'h0F01);
    chk("rej_done", {31'd0, bus.out_done}, 1);
    chk("rej_idle", {31'd0, bus.out_busy}, 0);
    tick();

    // Length 0 stays in passthrough
    base = en_cnt;
    load(8'hFF, 4'd0);
    chk("len0_busy", {31'd0, bus.out_busy}, 0);
    chk("len0_done", {31'd0, bus.out_done}, 0);
    send(16'h4321);
    chk("len0_frame", {16'd0, bus.out_frame}, 32'h4321);
    tick(); tick();
    chk("len0_no_en", en_cnt - base, 0);

    // Reset in BUSY aborts the sample
    load(8'h01, 4'd1);
    send(16'h7777);
    tick();
    base = rdy_cnt;
    in_rst = 1'b1;
    tick();
    chk("rstb_ready", {31'd0, bus.out_ready}, 0);
    chk("rstb_busy", {31'd0, bus.out_busy}, 0);
    chk("rstb_frame", {16'd0, bus.out_frame}, 0);
    chk("rstb_bc", {15'd0, bus.out_bc_enable, bus.out_bc_frame}, 0);
    chk("rstb_flags", {28'd0, bus.out_done, bus.out_overrun, bus.out_timeout, bus.out_load_rej}, 0);
    in_rst = 1'b0;
    repeat (10) tick();
    chk("rstb_no_ready", rdy_cnt - base, 0);

    chk("no_adjacent_ready", adj_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stego_seq_ctrl.md
Name: stego_seq_ctrl

Overview:
- Sequences the steganography datapath between uart2sample and sample2uart.
- Holds a loadable message and feeds it FRAME_SIZE bits per received sample into bit_changer_seq.
- Forwards the modified sample downstream, or the raw sample once no message is pending.
- Provides one-deep sample buffering, a bit_changer timeout, and status flags.

Parameters:
- BPS, 16, bits per sample.
- FRAME_SIZE, 1, message bits embedded per sample.
- MSG_BITS, 64, message buffer capacity in bits.
- TIMEOUT, 255, max cycles to wait for bit_changer out_ready (range 1..65535).

Ports:
- in_clk  in  1  clock; all logic on rising edge.
- in_rst  in  1  synchronous, active-high reset.
- in_msg_load  in  1  one-cycle message load strobe.
- in_msg_data  in  MSG_BITS  message; bit 0 is embedded first.
- in_msg_len  in  clog2(MSG_BITS+1)  message length in bits.
- in_sample_ready  in  1  uart2sample out_ready pulse.
- in_sample  in  FRAME_SIZE*BPS  uart2sample out_frame.
- out_bc_enable  out  1  one-cycle start pulse to bit_changer_seq in_enable.
- out_bc_frame  out  FRAME_SIZE*BPS  sample to bit_changer_seq.
- out_bc_message  out  FRAME_SIZE  message bits to bit_changer_seq.
- in_bc_ready  in  1  bit_changer_seq out_ready.
- in_bc_frame  in  FRAME_SIZE*BPS  bit_changer_seq out_frame.
- out_frame  out  FRAME_SIZE*BPS  sample to sample2uart in_sample.
- out_ready  out  1  one-cycle valid pulse to sample2uart.
- out_busy  out  1  high in ARMED or BUSY.
- out_done  out  1  sticky: message fully embedded.
- out_overrun  out  1  sticky: sample dropped.
- out_timeout  out  1  sticky: bit_changer timed out.
- out_load_rej  out  1  one-cycle pulse: load ignored.

Behaviour:
- Reset: state IDLE; all outputs 0; bit pointer 0; hold register empty; sticky flags cleared.
  - Reset mid-operation aborts any in-flight sample with no out_ready.
- States: IDLE, ARMED, BUSY, DONE.
- IDLE / DONE (passthrough):
  - A sample arriving at edge N gives out_frame = in_sample and out_ready = 1 at edge N+1.
  - out_bc_enable stays 0.
- Load:
  - Accepted in IDLE, ARMED and DONE: latch data and length, pointer = 0, clear out_done.
  - Non-zero length goes to ARMED. Length 0 goes to IDLE. Length > MSG_BITS is clamped to MSG_BITS.
  - A load in BUSY is ignored and pulses out_load_rej.
  - If a load and a sample arrive in the same cycle, the load is applied first and the sample uses the new message.
- ARMED:
  - On a sample (or a held sample): out_bc_frame = sample; out_bc_message = msg[ptr +: FRAME_SIZE].
  - Bits at or beyond len are 0.
  - out_bc_enable is pulsed for exactly 1 cycle; clear the timeout counter; go to BUSY.
- BUSY:
  - On in_bc_ready: out_frame = in_bc_frame and out_ready pulse on the next edge; ptr += FRAME_SIZE.
  - If ptr >= len: go to DONE and set out_done. Otherwise go to ARMED.
  - Timeout: if in_bc_ready is still absent after TIMEOUT cycles, set out_timeout, forward the raw latched sample with out_ready, leave ptr unchanged and go to ARMED.
  - A sample arriving in BUSY goes to the hold register if it is empty. If the hold register is full, the new sample is dropped and out_overrun is set.
- Hold register:
  - Drained first whenever the state allows a new sample.
  - In IDLE or DONE it drains as a passthrough.
  - A simultaneous new sample in the drain cycle refills the hold register.
- Ordering: out_ready pulses are never adjacent; there is at least one idle cycle between them so sample2uart can latch.
- Sticky flags clear only on in_rst. out_done also clears on an accepted load.

Optional Feature:
- Macro: STEGO_SEQ_CNT_EN.
- Defined:
  - Adds output out_sample_cnt [15:0]: counts out_ready pulses since reset or the last accepted load.
  - Wraps 0xFFFF -> 0.
  - Adds output out_embed_cnt [15:0]: counts samples forwarded from bit_changer.
- Not defined: neither port exists and no counters are synthesised.

Test Plan (BPS=16, FRAME_SIZE=1, MSG_BITS=8, TIMEOUT=16; bit_changer modelled as LSB replace, ready 3 cycles after enable):
- Passthrough: after reset, samples 0x3FFF and 0x01F0 with no load -> out_frame 0x3FFF then 0x01F0, each 1 cycle after input; out_bc_enable never asserted.
- Embed: load data=0x05, len=3; samples 0x3FFF, 0x3FFF, 0x3FFF, 0x1234 -> out_frame 0x3FFF, 0x3FFE, 0x3FFF, then passthrough 0x1234; out_done rises after the third sample.
- Buffering: load len=8; two samples back-to-back during BUSY, then a third while the hold register is full -> first two embedded in order; third dropped; out_overrun=1.
- Timeout: bit_changer ready suppressed; one sample 0xAAAA -> at 16 cycles out_timeout=1 and out_frame=0xAAAA; ptr unchanged, so the next sample carries msg bit 0.
- Load rules: load while BUSY -> out_load_rej pulse and message unchanged; load len=0 -> stays IDLE; in_rst asserted during BUSY -> all outputs 0 next cycle and no out_ready.
- With STEGO_SEQ_CNT_EN: the embed scenario gives out_sample_cnt=4 and out_embed_cnt=3.
